// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencer: FSM states, command
// opcodes and the default datapath width.
package counter_seq_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StPaused
    } state_e;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_PAUSE = 2'b11;

endpackage

// File: rtl/counter_core.sv
// Loadable down-counter; load has priority over decrement and the value
// saturates at zero.
module counter_core
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_dec_en,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec_en && (r_count != '0)) begin
            r_count <= r_count - ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command-driven sequencer: START/STOP/PAUSE handshake, prescaled stepping of
// counter_core, delayed one-cycle done pulse and optional auto-reload.
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DIV   = 2
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_op,
    input  logic [WIDTH-1:0] i_cmd_load,
    input  logic             i_cmd_autoreload,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_paused,
    output logic             o_done
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

    state_e           r_state;
    logic [WIDTH-1:0] r_reload;
    logic             r_autoreload;
    logic [PW-1:0]    r_presc;
    logic             r_done_pend;
    logic             r_done;

    logic             w_accept;
    logic             w_start;
    logic             w_stop;
    logic             w_pause;
    logic             w_step;
    logic             w_run_step;
    logic             w_one;
    logic             w_core_load;
    logic [WIDTH-1:0] w_core_value;
    logic             w_dec_en;

    assign o_cmd_ready = (r_state != StLoad);
    assign o_busy      = (r_state != StIdle);
    assign o_paused    = (r_state == StPaused);
    assign o_done      = r_done;

    assign w_accept   = i_cmd_valid && o_cmd_ready;
    assign w_start    = w_accept && (i_cmd_op == OP_START);
    assign w_stop     = w_accept && (i_cmd_op == OP_STOP);
    assign w_pause    = w_accept && (i_cmd_op == OP_PAUSE);
    assign w_step     = (r_state == StRun) && (r_presc == PS_LAST);
    // Any real command in the step cycle overrides the step.
    assign w_run_step = w_step && !(w_start || w_stop || w_pause);
    assign w_one      = (o_count == WIDTH'(1));

    // START preloads so the new value is already visible during LOAD.
    assign w_core_load  = w_start || (r_state == StLoad) ||
                          (w_run_step && w_one && r_autoreload);
    assign w_core_value = w_start ? i_cmd_load : r_reload;
    assign w_dec_en     = w_run_step && !(w_one && r_autoreload);

    counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_load      (w_core_load),
        .i_load_value(w_core_value),
        .i_dec_en    (w_dec_en),
        .o_count     (o_count)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_reload     <= '0;
            r_autoreload <= 1'b0;
            r_presc      <= '0;
            r_done_pend  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done      <= r_done_pend;
            r_done_pend <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_reload     <= i_cmd_load;
                        r_autoreload <= i_cmd_autoreload;
                        r_state      <= StLoad;
                    end
                end
                StLoad: begin
                    r_presc <= '0;
                    if (r_reload == '0) begin
                        r_done_pend <= !r_done_pend;
                        r_state     <= StIdle;
                    end else begin
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    if (w_start) begin
                        r_reload     <= i_cmd_load;
                        r_autoreload <= i_cmd_autoreload;
                        r_state      <= StLoad;
                    end else if (w_stop) begin
                        r_state <= StIdle;
                    end else if (w_pause) begin
                        r_state <= StPaused;
                    end else if (w_step) begin
                        r_presc <= '0;
                        if (w_one) begin
                            r_done_pend <= !r_done_pend;
                            if (!r_autoreload) begin
                                r_state <= StIdle;
                            end
                        end
                    end else begin
                        r_presc <= r_presc + PW'(1);
                    end
                end
                StPaused: begin
                    if (w_start) begin
                        r_reload     <= i_cmd_load;
                        r_autoreload <= i_cmd_autoreload;
                        r_state      <= StLoad;
                    end else if (w_stop) begin
                        r_state <= StIdle;
                    end else if (w_pause) begin
                        r_state <= StRun;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl (WIDTH=4, DIV=2): directed scenarios
// plus randomized commands against a cycle-indexed behavioural model.
module tb_counter_seq_ctrl;

    localparam int DIV = 2;
    localparam logic [1:0] NOP = 2'b00, START = 2'b01, STOP = 2'b10, PAUSE = 2'b11;
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_PAUSED = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = NOP;
    logic [3:0] cmd_load = '0;
    logic       cmd_ar = 1'b0;
    logic       cmd_ready;
    logic [3:0] count;
    logic       busy;
    logic       paused;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Behavioural model: m_cyc is the index of the cycle currently visible.
    int m_mode, m_count, m_reload, m_elapsed, m_cyc, m_due;
    bit m_ar;

    counter_seq_ctrl #(.WIDTH(4), .DIV(DIV)) dut (
        .i_clock         (clock),
        .i_reset         (reset),
        .i_cmd_valid     (cmd_valid),
        .o_cmd_ready     (cmd_ready),
        .i_cmd_op        (cmd_op),
        .i_cmd_load      (cmd_load),
        .i_cmd_autoreload(cmd_ar),
        .o_count         (count),
        .o_busy          (busy),
        .o_paused        (paused),
        .o_done          (done)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_mode = M_IDLE; m_count = 0; m_reload = 0; m_ar = 0;
        m_elapsed = 0; m_due = -1;
    endtask

    task automatic model_update(input bit v, input logic [1:0] op, input int ld, input bit ar);
        bit acc;
        acc = v && (m_mode != M_LOAD);
        if (acc && op == START && m_mode != M_LOAD) begin
            m_reload = ld; m_ar = ar; m_count = ld; m_mode = M_LOAD;
        end else begin
            case (m_mode)
                M_LOAD: begin
                    m_elapsed = 0;
                    m_count = m_reload;
                    if (m_reload == 0) begin m_mode = M_IDLE; m_due = m_cyc + 2; end
                    else m_mode = M_RUN;
                end
                M_RUN: begin
                    if (acc && op == STOP) m_mode = M_IDLE;
                    else if (acc && op == PAUSE) m_mode = M_PAUSED;
                    else if (m_elapsed == DIV - 1) begin
                        m_elapsed = 0;
                        if (m_count > 1) m_count--;
                        else begin
                            m_due = m_cyc + 2;
                            if (m_ar) m_count = m_reload;
                            else begin m_count = 0; m_mode = M_IDLE; end
                        end
                    end else m_elapsed++;
                end
                M_PAUSED: begin
                    if (acc && op == STOP) m_mode = M_IDLE;
                    else if (acc && op == PAUSE) m_mode = M_RUN;
                end
                default: ;
            endcase
        end
        m_cyc++;
    endtask

    task automatic tick(input bit v, input logic [1:0] op, input int ld, input bit ar);
        cmd_valid = v; cmd_op = op; cmd_load = 4'(ld); cmd_ar = ar;
        @(posedge clock);
        model_update(v, op, ld, ar);
        #1;
        cmd_valid = 1'b0; cmd_op = NOP;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || paused !== 1'b0) begin
            errors++; $display("FAIL reset_flags got r%b b%b d%b p%b exp r1 b0 d0 p0", cmd_ready, busy, done, paused);
        end
        @(negedge clock); reset = 1'b0; model_reset(); m_cyc = 0;
        tick(1, START, 9, 0);
        repeat (3) tick(0, NOP, 0, 0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b exp 1", busy); end
        #2; reset = 1'b1; model_reset();
        #1;
        checks++; if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset got c%0d b%b d%b r%b exp c0 b0 d0 r1", count, busy, done, cmd_ready);
        end
        @(negedge clock); reset = 1'b0;
        tick(0, NOP, 0, 0);
        checks++; if (count !== 4'(m_count) || busy !== 1'b0) begin
            errors++; $display("FAIL post_reset got c%0d b%b exp c%0d b0", count, busy, m_count);
        end
    endtask

    task automatic test_oneshot();
        int exp_cnt [11] = '{0, 3, 3, 3, 2, 2, 1, 1, 0, 0, 0};
        tick(1, START, 3, 0);
        for (int k = 1; k <= 10; k++) begin
            checks++; if (count !== 4'(exp_cnt[k])) begin
                errors++; $display("FAIL oneshot_count T+%0d got %0d exp %0d", k, count, exp_cnt[k]);
            end
            checks++; if (done !== (k == 9) || busy !== (k < 8)) begin
                errors++; $display("FAIL oneshot_flags T+%0d got d%b b%b exp d%b b%b", k, done, busy, k == 9, k < 8);
            end
            tick(0, NOP, 0, 0);
        end
    endtask

    task automatic test_autoreload();
        int t;
        t = m_cyc;
        tick(1, START, 2, 1);
        repeat (24) begin
            bit exp_done;
            exp_done = (m_cyc >= t + 7) && (((m_cyc - t - 7) % 4) == 0);
            checks++; if (done !== exp_done || count === 4'd0 || busy !== 1'b1 || count !== 4'(m_count)) begin
                errors++; $display("FAIL autoreload T+%0d got c%0d d%b b%b exp c%0d d%b b1",
                                   m_cyc - t, count, done, busy, m_count, exp_done);
            end
            tick(0, NOP, 0, 0);
        end
        tick(1, STOP, 0, 0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL autoreload_stop got b%b exp 0", busy); end
        repeat (3) tick(0, NOP, 0, 0);
    endtask

    task automatic test_pause();
        int t;
        t = m_cyc;
        tick(1, START, 5, 0);
        repeat (3) tick(0, NOP, 0, 0);
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL pause_first_dec got %0d exp 4", count); end
        tick(1, PAUSE, 0, 0);
        for (int i = 0; i < 10; i++) begin
            checks++; if (count !== 4'd4 || paused !== 1'b1 || busy !== 1'b1) begin
                errors++; $display("FAIL pause_hold i%0d got c%0d p%b b%b exp c4 p1 b1", i, count, paused, busy);
            end
            if (i == 9) tick(1, PAUSE, 0, 0); else tick(0, NOP, 0, 0);
        end
        while (m_cyc < t + 28) begin
            checks++; if (done !== (m_cyc == t + 24) || count !== 4'(m_count) || paused !== 1'b0) begin
                errors++; $display("FAIL pause_resume T+%0d got c%0d d%b p%b exp c%0d d%b p0",
                                   m_cyc - t, count, done, paused, m_count, m_cyc == t + 24);
            end
            tick(0, NOP, 0, 0);
        end
    endtask

    task automatic test_load_zero();
        tick(1, START, 0, 1);
        checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL zero_load_cycle got r%b b%b exp r0 b1", cmd_ready, busy);
        end
        tick(0, NOP, 0, 0);
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL zero_idle got r%b b%b d%b exp r1 b0 d0", cmd_ready, busy, done);
        end
        tick(0, NOP, 0, 0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b exp 1", done); end
        for (int i = 0; i < 8; i++) begin
            tick(0, NOP, 0, 0);
            checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++; $display("FAIL zero_single i%0d got d%b r%b exp d0 r1", i, done, cmd_ready);
            end
        end
    endtask

    task automatic test_collision();
        tick(1, START, 1, 0);
        checks++; if (cmd_ready !== 1'b0 || count !== 4'd1) begin
            errors++; $display("FAIL coll_load got r%b c%0d exp r0 c1", cmd_ready, count);
        end
        tick(1, START, 9, 0);
        checks++; if (count !== 4'd1 || busy !== 1'b1) begin
            errors++; $display("FAIL coll_ignored got c%0d b%b exp c1 b1", count, busy);
        end
        tick(0, NOP, 0, 0);
        tick(1, STOP, 0, 0);
        checks++; if (busy !== 1'b0 || count !== 4'd1) begin
            errors++; $display("FAIL coll_stop got b%b c%0d exp b0 c1", busy, count);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, NOP, 0, 0);
            checks++; if (done !== 1'b0 || count !== 4'd1) begin
                errors++; $display("FAIL coll_nodone i%0d got d%b c%0d exp d0 c1", i, done, count);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit v;
            logic [1:0] op;
            int r;
            r = int'($urandom_range(0, 19));
            v = (r < 5);
            op = (r < 2) ? START : (r == 2) ? STOP : (r == 3) ? PAUSE : NOP;
            tick(v, op, int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
            checks++; if (count !== 4'(m_count) || done !== (m_cyc == m_due) ||
                          busy !== (m_mode != M_IDLE) || paused !== (m_mode == M_PAUSED) ||
                          cmd_ready !== (m_mode != M_LOAD)) begin
                errors++; $display("FAIL random cyc%0d got c%0d d%b b%b p%b r%b exp c%0d d%b mode%0d",
                                   m_cyc, count, done, busy, paused, cmd_ready, m_count,
                                   m_cyc == m_due, m_mode);
            end
        end
    endtask

    initial begin
        model_reset();
        m_cyc = 0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_pause();
        test_load_zero();
        test_collision();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Command-driven sequencer for the team's 4-bit counter datapath.
- Accepts START/STOP/PAUSE commands over a valid/ready handshake.
- Loads a start value into a down-counter and paces decrements with an internal prescaler.
- Signals completion with a one-cycle done pulse; optional auto-reload turns it into a periodic tick source for downstream logic.

Parameters:
WIDTH, 4, counter width in bits
DIV, 2, clock cycles per count step while running (DIV >= 1)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command this cycle
cmd_op  input  2  00 NOP, 01 START, 10 STOP, 11 PAUSE (toggle pause/resume)
cmd_load  input  WIDTH  start value, sampled only on accepted START
cmd_autoreload  input  1  sampled on accepted START; 1 = reload on reaching end of count
count  output  WIDTH  current counter value
busy  output  1  high in LOAD, RUN, PAUSED
paused  output  1  high in PAUSED
done  output  1  one-cycle pulse at end of count

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-high (reset).
- Reset values: state IDLE, count 0, reload register 0, autoreload flag 0, prescaler 0, done 0, busy 0, paused 0, cmd_ready 1.
- Handshake: a command is accepted when cmd_valid && cmd_ready. cmd_ready = (state != LOAD). NOP is accepted with no effect.
- States: IDLE, LOAD, RUN, PAUSED.
- IDLE:
  - START: capture cmd_load into the reload register and cmd_autoreload into the flag, then go to LOAD.
  - STOP and PAUSE: accepted, no effect.
- LOAD (exactly one cycle):
  - count <= reload register; prescaler <= 0.
  - If reload == 0: done pulses next cycle, go to IDLE. Auto-reload is ignored in this case, so no endless pulses occur.
  - Otherwise go to RUN.
- RUN:
  - Prescaler counts 0..DIV-1. The cycle where prescaler == DIV-1 is a step; the prescaler wraps to 0.
  - Step with count > 1: count decrements by 1.
  - Step with count == 1, autoreload 0: count <= 0, done pulses the next cycle, go to IDLE.
  - Step with count == 1, autoreload 1: count <= reload, done pulses, stay in RUN. Count never shows 0 in this case.
  - PAUSE: go to PAUSED. Prescaler and count freeze, and no step occurs in that cycle.
  - STOP: go to IDLE with count held.
  - START: restart via LOAD with the new values.
- PAUSED:
  - PAUSE: return to RUN; the prescaler resumes from its frozen value.
  - STOP: go to IDLE.
  - START: go to LOAD.
- Precedence when a command and a step share a cycle: the command wins. STOP or START on a terminal step gives no done pulse.
- done: registered, asserted exactly one cycle after the terminal-step edge, never two cycles in a row.
- Latency: accepted START at cycle T gives count = load at T+1 (LOAD) and RUN at T+2. First decrement becomes visible at T+2+DIV.
- Reset mid-operation: everything returns to reset values immediately (asynchronous); any pending done is dropped.
- Arithmetic: count is unsigned WIDTH bits. A decrement never wraps below 0.

Decomposition:
- Package counter_seq_pkg holds:
  - the state enum (IDLE, LOAD, RUN, PAUSED);
  - the op encodings (OP_NOP, OP_START, OP_STOP, OP_PAUSE);
  - the default width constant.
- Sub-module counter_core: loadable WIDTH-bit down-counter with load, load_value, dec_en and count output; same clock and async reset.
- The FSM, prescaler and done logic live in counter_seq_ctrl.

Test Plan (all scenarios use WIDTH=4, DIV=2):
- Reset: pulse reset high mid-cycle → count=0, busy=0, done=0 and cmd_ready=1 without waiting for a clock edge.
- One-shot: START load=3, autoreload=0 at T → count 3 at T+1, then 2 at T+4, 1 at T+6, 0 at T+8. done high only at T+9; busy=0 from T+8.
- Auto-reload: START load=2, autoreload=1 → done pulses every 4 cycles (2 steps × DIV). Count sequence is 2,1,2,1…; stays busy; never reads 0.
- Pause/resume: START load=5, PAUSE after first decrement (count=4) → count holds 4 and paused=1 for 10 cycles. Second PAUSE resumes; total decrements and done timing shift by exactly the pause duration.
- Load zero: START load=0, autoreload=1 → LOAD one cycle, then a single done pulse, then IDLE. cmd_ready is 0 only during the LOAD cycle.
- Collision: STOP issued in the terminal-step cycle of load=1 → no done pulse, state IDLE, count=1. A command offered during LOAD is not accepted (cmd_ready=0).
